// File: rtl/ml_pkg.sv
// Shared defaults and helpers for the match logger slice.
package ml_pkg;

    localparam int PW_DEF    = 16;
    localparam int DEPTH_DEF = 4;
    localparam int MCNT_MAX  = 255;

    // FIFO control bundle driven by the logger each cycle.
    typedef struct packed {
        logic push;
        logic pop;
        logic clr;
    } fifo_ctl_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'(MCNT_MAX)) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ml_fifo.sv
// Position FIFO: power-of-two ring with a 0..DEPTH occupancy counter.
module ml_fifo
    import ml_pkg::*;
#(
    parameter int W     = PW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  fifo_ctl_t    ctl,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          do_pop;
    logic          do_push;

    assign full  = (occ == (AW+1)'(DEPTH));
    assign empty = (occ == '0);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
    assign do_pop  = ctl.pop & ~empty;
    assign do_push = ctl.push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (ctl.clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            occ <= occ + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !ctl.clr) mem[wr_ptr] <= wdata;
    end

    // Storage is not reset; masking keeps the head at zero whenever nothing is queued.
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/match_logger.sv
// Logs the byte position of every detector match into a small FIFO,
// with a saturating match count and a sticky drop flag.
module match_logger
    import ml_pkg::*;
#(
    parameter int PW    = PW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          eureka,
    input  logic          clr,
    input  logic          pos_ready,
    output logic          pos_valid,
    output logic [PW-1:0] pos_data,
    output logic [7:0]    match_cnt,
    output logic          overflow,
    output logic          full
);

    logic [PW-1:0] pos_cnt;
    logic          match;
    logic          empty;
    logic          popping;
    fifo_ctl_t     ctl;

    assign match     = en & eureka;
    assign pos_valid = ~empty;
    assign popping   = pos_ready & pos_valid;
    assign ctl       = '{push: match, pop: pos_ready, clr: clr};

    ml_fifo #(
        .W     (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .ctl   (ctl),
        .wdata (pos_cnt),
        .rdata (pos_data),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_cnt   <= '0;
            match_cnt <= '0;
            overflow  <= 1'b0;
        end else if (clr) begin
            pos_cnt   <= '0;
            match_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (en)    pos_cnt   <= pos_cnt + PW'(1);
            if (match) match_cnt <= sat_inc(match_cnt);
            if (match && full && !popping) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_match_logger.sv
// Directed bench for match_logger: vector table plus reset/wrap/saturation sequences.
module tb_match_logger;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, eureka = 1'b0, clr = 1'b0, pos_ready = 1'b0;
    logic        v16, o16, f16, v4, o4, f4;
    logic [15:0] d16;
    logic [3:0]  d4;
    logic [7:0]  c16, c4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    match_logger #(.PW(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .eureka(eureka), .clr(clr), .pos_ready(pos_ready),
        .pos_valid(v16), .pos_data(d16), .match_cnt(c16), .overflow(o16), .full(f16)
    );

    match_logger #(.PW(4), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .eureka(eureka), .clr(clr), .pos_ready(pos_ready),
        .pos_valid(v4), .pos_data(d4), .match_cnt(c4), .overflow(o4), .full(f4)
    );

    typedef struct {
        logic        en, eu, clr, rdy;
        logic        v;
        logic [15:0] d;
        logic [7:0]  c;
        logic        o, f;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic u, input logic c, input logic r,
                       input logic v, input logic [15:0] d, input logic [7:0] cnt,
                       input logic o, input logic f);
        vec_t t;
        t.en = e; t.eu = u; t.clr = c; t.rdy = r;
        t.v = v; t.d = d; t.c = cnt; t.o = o; t.f = f;
        vq.push_back(t);
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic drive(input logic e, input logic u, input logic c, input logic r);
        en = e; eureka = u; clr = c; pos_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [15:0] d,
                           input logic [7:0] cnt, input logic o, input logic f);
        chk({tag, "_valid"}, 32'(v16), 32'(v));
        chk({tag, "_data"},  32'(d16), 32'(d));
        chk({tag, "_cnt"},   32'(c16), 32'(cnt));
        chk({tag, "_ovf"},   32'(o16), 32'(o));
        chk({tag, "_full"},  32'(f16), 32'(f));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Bytes 0..9, match on byte 7, then drain.
        for (int b = 0; b < 10; b++)
            add(1, b == 7, 0, 0, b >= 7, (b >= 7) ? 16'd7 : 16'd0, (b >= 7) ? 8'd1 : 8'd0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1, 0, 0);
        // Clear (with a coincident match), then matches on 3,4,5 and ordered drain.
        add(1, 1, 1, 1, 0, 0, 0, 0, 0);
        for (int b = 0; b < 6; b++)
            add(1, b >= 3, 0, 0, b >= 3, (b >= 3) ? 16'd3 : 16'd0, (b >= 3) ? 8'(b - 2) : 8'd0, 0, 0);
        add(0, 0, 0, 1, 1, 4, 3, 0, 0);
        add(0, 0, 0, 1, 1, 5, 3, 0, 0);
        add(0, 0, 0, 1, 0, 0, 3, 0, 0);
        add(0, 0, 0, 1, 0, 0, 3, 0, 0);
        // Fill to DEPTH, drop the fifth, drain 1..4.
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int b = 1; b < 6; b++)
            add(1, 1, 0, 0, 1, 1, 8'(b), b == 5, b >= 4);
        add(0, 0, 0, 1, 1, 2, 5, 1, 0);
        add(0, 0, 0, 1, 1, 3, 5, 1, 0);
        add(0, 0, 0, 1, 1, 4, 5, 1, 0);
        add(0, 0, 0, 1, 0, 0, 5, 1, 0);
        // Full with simultaneous push and pop; new entry comes out last.
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int b = 0; b < 4; b++)
            add(1, 1, 0, 0, 1, 0, 8'(b + 1), 0, b == 3);
        add(1, 1, 0, 1, 1, 1, 5, 0, 1);
        add(0, 0, 0, 1, 1, 2, 5, 0, 0);
        add(0, 0, 0, 1, 1, 3, 5, 0, 0);
        add(0, 0, 0, 1, 1, 4, 5, 0, 0);
        add(0, 0, 0, 1, 0, 0, 5, 0, 0);
        // Occupancy 1 with push and pop: new entry becomes head.
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 0, 1, 0, 0);
        add(1, 1, 0, 1, 1, 1, 2, 0, 0);
        add(0, 0, 0, 1, 0, 0, 2, 0, 0);

        // Reset held with active inputs: everything stays zero.
        en = 1'b1; eureka = 1'b1; pos_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        chk("reset_pw4_cnt", 32'(c4), 32'd0);
        en = 1'b0; eureka = 1'b0; pos_ready = 1'b0;
        rst = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i].en, vq[i].eu, vq[i].clr, vq[i].rdy);
            chk_all($sformatf("vec%0d", i), vq[i].v, vq[i].d, vq[i].c, vq[i].o, vq[i].f);
        end

        // Position wrap: 17th byte is index 16, which is 0 at PW=4.
        drive(1, 1, 1, 0);
        chk_all("wrap_clr", 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) drive(1, 0, 0, 0);
        chk("wrap_pre_valid", 32'(v4), 32'd0);
        drive(1, 1, 0, 0);
        chk("wrap_pw4_valid", 32'(v4), 32'd1);
        chk("wrap_pw4_data", 32'(d4), 32'd0);
        chk("wrap_pw16_data", 32'(d16), 32'd16);

        // Saturation with a stalled consumer, then clear alongside a match.
        drive(1, 1, 1, 0);
        for (int i = 1; i <= 300; i++) begin
            drive(1, 1, 0, 0);
            if (i == 254) chk("sat_254", 32'(c16), 32'd254);
            if (i == 255) chk("sat_255", 32'(c16), 32'd255);
        end
        chk_all("sat_300", 1, 0, 255, 1, 1);
        chk("sat_pw4_cnt", 32'(c4), 32'd255);
        drive(1, 1, 1, 0);
        chk_all("clr_match", 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1);
        chk_all("clr_nowrite", 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0);
        chk_all("clr_pos0", 1, 0, 1, 0, 0);

        // Asynchronous reset mid-operation, away from any clock edge.
        drive(1, 1, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        drive(1, 1, 0, 1);
        chk_all("rst_held", 0, 0, 0, 0, 0);
        rst = 1'b1;
        drive(1, 1, 0, 0);
        chk_all("post_rst_b0", 1, 0, 1, 0, 0);
        drive(1, 1, 0, 0);
        chk_all("post_rst_b1", 1, 0, 2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
